util_avl2fifo: RTL and testbench

Avalon-ST sink to FIFO write-port adapter for the 5G TX datapath; the upstream counterpart of the FIFO-to-Avalon valid aligner. It accepts beats from an Avalon-ST source that honours a configurable ready latency and writes each accepted beat into a synchronous FIFO together with per-symbol enables and packet markers. It generates `avl_ready` from the FIFO fill level with enough headroom to absorb every in-flight beat. It also flags protocol, overflow and (optionally) framing violations.

---
 rtl/util_avl2fifo_if.sv | 78 +++++++
 rtl/util_avl2fifo.sv | 238 +++++++++++++++++++++++
 tb/tb_util_avl2fifo.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/util_avl2fifo_if.sv
// ---------------------------------------------------------------------------
// util_avl2fifo_if
//
// Purpose: groups the Avalon-ST sink handshake and the FIFO write port that
// util_avl2fifo sits between. The adapter connects through the "slave"
// modport. The environment connects through the "master" modport: the
// upstream source, the FIFO write side and the FIFO level feedback.
//
// Parameters:
//   DATA_WIDTH - beat width (4 symbols, symbol 3 in the MSBs)
//   FIFO_AW    - FIFO address width; fifo_level is FIFO_AW+1 bits wide
//
// Signals:
//   avl_ready  - sink ready, driven by the adapter
//   avl_valid  - source valid
//   avl_data   - beat data
//   avl_sop    - start of packet
//   avl_eop    - end of packet
//   avl_empty  - empty symbols on the eop beat (LSB end)
//   fifo_wr    - FIFO write strobe
//   fifo_wdata - FIFO write data
//   fifo_wen   - per-symbol enables, bit 3 = MSB symbol
//   fifo_wsop  - sop marker stored with the beat
//   fifo_weop  - eop marker stored with the beat
//   fifo_level - FIFO occupancy, 0..2**FIFO_AW
// ---------------------------------------------------------------------------
interface util_avl2fifo_if #(
  parameter int DATA_WIDTH = 128,
  parameter int FIFO_AW    = 9
);

  logic                  avl_ready;
  logic                  avl_valid;
  logic [DATA_WIDTH-1:0] avl_data;
  logic                  avl_sop;
  logic                  avl_eop;
  logic [1:0]            avl_empty;

  logic                  fifo_wr;
  logic [DATA_WIDTH-1:0] fifo_wdata;
  logic [3:0]            fifo_wen;
  logic                  fifo_wsop;
  logic                  fifo_weop;
  logic [FIFO_AW:0]      fifo_level;

  // Adapter side: consumes the stream, produces FIFO writes.
  modport slave (
    output avl_ready,
    input  avl_valid,
    input  avl_data,
    input  avl_sop,
    input  avl_eop,
    input  avl_empty,
    output fifo_wr,
    output fifo_wdata,
    output fifo_wen,
    output fifo_wsop,
    output fifo_weop,
    input  fifo_level
  );

  // Environment side: stream source plus FIFO write port and level.
  modport master (
    input  avl_ready,
    output avl_valid,
    output avl_data,
    output avl_sop,
    output avl_eop,
    output avl_empty,
    input  fifo_wr,
    input  fifo_wdata,
    input  fifo_wen,
    input  fifo_wsop,
    input  fifo_weop,
    output fifo_level
  );

endinterface

// File: rtl/util_avl2fifo.sv
// ---------------------------------------------------------------------------
// util_avl2fifo
//
// Purpose: Avalon-ST sink to synchronous-FIFO write-port adapter. It accepts
// beats from a source that honours READY_LATENCY and writes each accepted
// beat into the FIFO one cycle later, together with symbol enables and
// packet markers. Ready is derived from the FIFO level with enough reserve
// to absorb every beat still in flight. Protocol, overflow and (optionally)
// framing violations are reported as sticky flags.
//
// Optional feature: define UTIL_AVL2FIFO_FRAMING_CHECK_EN to compile in the
// sop/eop framing checker. Without it every accepted, non-overflowing beat
// is written and err_framing is tied to 0.
//
// Parameters:
//   DATA_WIDTH    - beat width, 4 symbols of DATA_WIDTH/4 bits
//   READY_LATENCY - Avalon-ST ready latency, 0..4
//   FIFO_AW       - FIFO address width, depth 2**FIFO_AW
//   HEADROOM      - extra free entries kept in reserve before ready drops
//
// Ports:
//   clk          - clock, rising edge
//   rst_n        - asynchronous active-low reset
//   bus          - stream sink + FIFO write port (util_avl2fifo_if.slave)
//   err_clr      - clears the sticky error flags
//   err_protocol - sticky: valid asserted outside the ready window
//   err_overflow - sticky: beat accepted while the FIFO was full
//   err_framing  - sticky: sop/eop sequence violation
//   beat_cnt     - number of beats written, wraps at 16 bits
// ---------------------------------------------------------------------------
module util_avl2fifo #(
  parameter int DATA_WIDTH    = 128,
  parameter int READY_LATENCY = 2,
  parameter int FIFO_AW       = 9,
  parameter int HEADROOM      = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  util_avl2fifo_if.slave       bus,
  input  logic                 err_clr,
  output logic                 err_protocol,
  output logic                 err_overflow,
  output logic                 err_framing,
  output logic [15:0]          beat_cnt
);

  localparam int DEPTH  = 2 ** FIFO_AW;
  // Registered ready plus the write stage add two cycles on top of the
  // source's ready latency before a level change can stop the stream.
  localparam int THRESH = READY_LATENCY + 2 + HEADROOM;
  localparam int LW     = FIFO_AW + 2;

  logic [LW-1:0]            free_cnt;
  logic                     ready_next;
  logic [READY_LATENCY:0]   rdy_dly;
  logic                     win;

  logic                     accept;
  logic                     prot_err;
  logic                     level_full;
  logic                     ovf_err;
  logic                     beat_ok;
  logic                     frame_drop;
  logic                     frame_err;
  logic                     wr_en;
  logic [3:0]               wen_next;

  logic                     fifo_wr_q;
  logic [DATA_WIDTH-1:0]    fifo_wdata_q;
  logic [3:0]               fifo_wen_q;
  logic                     fifo_wsop_q;
  logic                     fifo_weop_q;
  logic [15:0]              beat_cnt_q;
  logic                     err_protocol_q;
  logic                     err_overflow_q;

  // -------------------------------------------------------------------------
  // Ready generation and ready window
  // -------------------------------------------------------------------------
  assign free_cnt   = LW'(DEPTH) - LW'(bus.fifo_level);
  assign ready_next = free_cnt > LW'(THRESH);

  // Bit k holds avl_ready as it was k cycles ago; bit 0 is the registered
  // avl_ready itself. A beat is legal when ready was high exactly
  // READY_LATENCY cycles before it, which is the top bit for any latency,
  // including 0 where the window is avl_ready itself.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_dly <= '0;
    end else begin
      rdy_dly <= (rdy_dly << 1) | (READY_LATENCY + 1)'(ready_next);
    end
  end

  assign bus.avl_ready = rdy_dly[0];
  assign win           = rdy_dly[READY_LATENCY];

  // -------------------------------------------------------------------------
  // Beat qualification
  // -------------------------------------------------------------------------
  assign accept     = bus.avl_valid && win;
  assign prot_err   = bus.avl_valid && !win;
  assign level_full = (bus.fifo_level == (FIFO_AW + 1)'(DEPTH));
  assign ovf_err    = accept && level_full;
  assign beat_ok    = accept && !level_full;
  assign wr_en      = beat_ok && !frame_drop;

  // Empty symbols are counted from the LSB end, so each empty symbol clears
  // one more enable bit from the bottom.
  always_comb begin
    wen_next = 4'b1111;
    if (bus.avl_eop) begin
      case (bus.avl_empty)
        2'd0:    wen_next = 4'b1111;
        2'd1:    wen_next = 4'b1110;
        2'd2:    wen_next = 4'b1100;
        default: wen_next = 4'b1000;
      endcase
    end
  end

`ifdef UTIL_AVL2FIFO_FRAMING_CHECK_EN
  // -------------------------------------------------------------------------
  // Framing checker
  // -------------------------------------------------------------------------
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PKT  = 1'b1
  } frame_state_t;

  frame_state_t state_q;
  frame_state_t state_d;
  logic         err_framing_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Only beats that actually reach the FIFO advance the tracker, so a beat
  // lost to overflow leaves the packet state untouched. An unexpected sop
  // inside a packet is flagged but still written as a fresh packet start,
  // which lets the stream resynchronise on the next sop.
  always_comb begin
    state_d    = state_q;
    frame_drop = 1'b0;
    frame_err  = 1'b0;
    if (beat_ok) begin
      case (state_q)
        ST_IDLE: begin
          if (!bus.avl_sop) begin
            frame_drop = 1'b1;
            frame_err  = 1'b1;
          end else if (!bus.avl_eop) begin
            state_d = ST_PKT;
          end
        end
        ST_PKT: begin
          if (bus.avl_sop) begin
            frame_err = 1'b1;
          end
          if (bus.avl_eop) begin
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // A new violation in the same cycle as err_clr keeps the flag set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_framing_q <= 1'b0;
    end else begin
      err_framing_q <= (err_framing_q && !err_clr) || frame_err;
    end
  end

  assign err_framing = err_framing_q;
`else
  assign frame_drop  = 1'b0;
  assign frame_err   = 1'b0;
  assign err_framing = 1'b0;
`endif

  // -------------------------------------------------------------------------
  // Write stage
  // -------------------------------------------------------------------------
  // Data and markers only move on a write, so the FIFO side sees stable
  // values between strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_wr_q    <= 1'b0;
      fifo_wdata_q <= '0;
      fifo_wen_q   <= 4'b0000;
      fifo_wsop_q  <= 1'b0;
      fifo_weop_q  <= 1'b0;
      beat_cnt_q   <= 16'd0;
    end else begin
      fifo_wr_q <= wr_en;
      if (wr_en) begin
        fifo_wdata_q <= bus.avl_data;
        fifo_wen_q   <= wen_next;
        fifo_wsop_q  <= bus.avl_sop;
        fifo_weop_q  <= bus.avl_eop;
        beat_cnt_q   <= beat_cnt_q + 16'd1;
      end
    end
  end

  assign bus.fifo_wr    = fifo_wr_q;
  assign bus.fifo_wdata = fifo_wdata_q;
  assign bus.fifo_wen   = fifo_wen_q;
  assign bus.fifo_wsop  = fifo_wsop_q;
  assign bus.fifo_weop  = fifo_weop_q;
  assign beat_cnt       = beat_cnt_q;

  // -------------------------------------------------------------------------
  // Sticky protocol and overflow flags
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_protocol_q <= 1'b0;
      err_overflow_q <= 1'b0;
    end else begin
      err_protocol_q <= (err_protocol_q && !err_clr) || prot_err;
      err_overflow_q <= (err_overflow_q && !err_clr) || ovf_err;
    end
  end

  assign err_protocol = err_protocol_q;
  assign err_overflow = err_overflow_q;

endmodule

// File: tb/tb_util_avl2fifo.sv
// ---------------------------------------------------------------------------
// tb_util_avl2fifo
//
// Purpose: self-checking bench for util_avl2fifo with READY_LATENCY=2,
// FIFO depth 16 and HEADROOM=2 (ready high iff fifo_level <= 9). Expected
// FIFO writes are queued when a beat is issued and a monitor compares them
// against the write port. Ready, sticky flags and beat count are compared
// every cycle. Define UTIL_AVL2FIFO_FRAMING_CHECK_EN for both bench and RTL
// to cover the framing checker.
// ---------------------------------------------------------------------------
module tb_util_avl2fifo;

  localparam int DW    = 128;
  localparam int RL    = 2;
  localparam int AW    = 4;
  localparam int HR    = 2;
  localparam int DEPTH = 2 ** AW;
  // Highest level at which the sink may still advertise ready.
  localparam int MAX_READY_LEVEL = DEPTH - (RL + 2 + HR) - 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        err_clr = 1'b0;
  logic        err_protocol;
  logic        err_overflow;
  logic        err_framing;
  logic [15:0] beat_cnt;

  util_avl2fifo_if #(.DATA_WIDTH(DW), .FIFO_AW(AW)) bus ();

  util_avl2fifo #(
    .DATA_WIDTH(DW),
    .READY_LATENCY(RL),
    .FIFO_AW(AW),
    .HEADROOM(HR)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus),
    .err_clr(err_clr),
    .err_protocol(err_protocol),
    .err_overflow(err_overflow),
    .err_framing(err_framing),
    .beat_cnt(beat_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] data;
    logic [3:0]    wen;
    logic          sop;
    logic          eop;
    int            stamp;
  } wr_t;

  wr_t         exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;

  // Reference state: ready per cycle (index 0 = current), sticky flags,
  // expected beat count and whether a packet is open.
  bit          ready_hist[$];
  bit          m_prot;
  bit          m_ovf;
  bit          m_frm;
  bit          m_in_pkt;
  logic [15:0] m_cnt;
  logic [3:0]  wen_tab [4] = '{4'b1111, 4'b1110, 4'b1100, 4'b1000};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [DW-1:0] act,
                             input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Write monitor: every strobe must match the oldest expected write and
  // appear exactly one cycle after its beat was sampled.
  always @(negedge clk) begin : monitor
    wr_t e;
    if (rst_n) begin
      while (exp_q.size() > 0 && exp_q[0].stamp < cyc) begin
        checks++;
        errors++;
        $display("[TB] FAIL missed_write: fifo_wr=0 expected 1 (cycle %0d)", exp_q[0].stamp);
        void'(exp_q.pop_front());
      end
      if (bus.fifo_wr) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL spurious_write: fifo_wr=1 expected 0 (cycle %0d)", cyc);
        end else begin
          e = exp_q.pop_front();
          checkOutput("wr_cycle", DW'(cyc), DW'(e.stamp));
          checkOutput("fifo_wdata", bus.fifo_wdata, e.data);
          checkOutput("fifo_wen", DW'(bus.fifo_wen), DW'(e.wen));
          checkOutput("fifo_wsop", DW'(bus.fifo_wsop), DW'(e.sop));
          checkOutput("fifo_weop", DW'(bus.fifo_weop), DW'(e.eop));
        end
      end
    end
  end

  task automatic modelReset();
    exp_q.delete();
    ready_hist.delete();
    for (int i = 0; i <= RL; i++) ready_hist.push_back(1'b0);
    m_prot   = 1'b0;
    m_ovf    = 1'b0;
    m_frm    = 1'b0;
    m_in_pkt = 1'b0;
    m_cnt    = 16'd0;
  endtask

  // One clock cycle of stimulus: compare status, drive inputs, predict.
  task automatic applyStimulus(input bit v, input bit sop, input bit eop,
                               input bit [1:0] emp, input int lvl, input bit clr);
    logic [DW-1:0] d;
    bit win;
    bit full;
    bit new_prot;
    bit new_ovf;
    bit new_frm;
    bit do_wr;
    @(negedge clk);
    checkOutput("avl_ready", DW'(bus.avl_ready), DW'(ready_hist[0]));
    checkOutput("err_protocol", DW'(err_protocol), DW'(m_prot));
    checkOutput("err_overflow", DW'(err_overflow), DW'(m_ovf));
    checkOutput("err_framing", DW'(err_framing), DW'(m_frm));
    checkOutput("beat_cnt", DW'(beat_cnt), DW'(m_cnt));
    d = {$urandom(), $urandom(), $urandom(), $urandom()};
    bus.avl_valid  = v;
    bus.avl_data   = d;
    bus.avl_sop    = sop;
    bus.avl_eop    = eop;
    bus.avl_empty  = emp;
    bus.fifo_level = lvl[AW:0];
    err_clr        = clr;

    win      = ready_hist[RL];
    full     = (lvl == DEPTH);
    new_prot = v && !win;
    new_ovf  = v && win && full;
    new_frm  = 1'b0;
    do_wr    = v && win && !full;
`ifdef UTIL_AVL2FIFO_FRAMING_CHECK_EN
    if (do_wr && !m_in_pkt && !sop) begin
      do_wr   = 1'b0;
      new_frm = 1'b1;
    end else if (do_wr && m_in_pkt && sop) begin
      new_frm = 1'b1;
    end
`endif
    if (do_wr) begin
      exp_q.push_back('{data: d, wen: (eop ? wen_tab[emp] : 4'b1111),
                        sop: sop, eop: eop, stamp: cyc + 1});
      m_cnt    = m_cnt + 16'd1;
      m_in_pkt = !eop;
    end
    m_prot = (m_prot && !clr) || new_prot;
    m_ovf  = (m_ovf && !clr) || new_ovf;
    m_frm  = (m_frm && !clr) || new_frm;

    @(posedge clk);
    ready_hist.push_front(lvl <= MAX_READY_LEVEL);
    void'(ready_hist.pop_back());
  endtask

  // Idle until the source may legally present a beat, then present it.
  task automatic sendBeat(input bit sop, input bit eop, input bit [1:0] emp, input int lvl);
    int n = 0;
    while (!ready_hist[RL] && n < 50) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 2'd0, lvl, 1'b0);
      n++;
    end
    if (!ready_hist[RL]) begin
      checks++;
      errors++;
      $display("[TB] FAIL ready_timeout: window=0 expected 1 after %0d cycles", n);
    end else begin
      applyStimulus(1'b1, sop, eop, emp, lvl, 1'b0);
    end
  endtask

  task automatic idle(input int n, input int lvl);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, 2'd0, lvl, 1'b0);
  endtask

  task automatic resetDut();
    @(negedge clk);
    #2;
    rst_n          = 1'b0;
    bus.avl_valid  = 1'b0;
    bus.avl_data   = '0;
    bus.avl_sop    = 1'b0;
    bus.avl_eop    = 1'b0;
    bus.avl_empty  = 2'd0;
    bus.fifo_level = '0;
    err_clr        = 1'b0;
    modelReset();
    #1;
    checkOutput("rst_avl_ready", DW'(bus.avl_ready), '0);
    checkOutput("rst_fifo_wr", DW'(bus.fifo_wr), '0);
    checkOutput("rst_fifo_wdata", bus.fifo_wdata, '0);
    checkOutput("rst_fifo_wen", DW'(bus.fifo_wen), '0);
    checkOutput("rst_fifo_wsop", DW'(bus.fifo_wsop), '0);
    checkOutput("rst_fifo_weop", DW'(bus.fifo_weop), '0);
    checkOutput("rst_err_protocol", DW'(err_protocol), '0);
    checkOutput("rst_err_overflow", DW'(err_overflow), '0);
    checkOutput("rst_err_framing", DW'(err_framing), '0);
    checkOutput("rst_beat_cnt", DW'(beat_cnt), '0);
    @(negedge clk);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    ready_hist.push_front(1'b1);
    void'(ready_hist.pop_back());
  endtask

  initial begin
    bit v;
    bit s;
    bit e;
    int r;
    int lvl;
    modelReset();
    resetDut();

    $display("[TB] single-beat packets at level 0");
    for (int i = 0; i < 8; i++) sendBeat(1'b1, 1'b1, 2'd0, 0);
    idle(2, 0);
    checkOutput("beat_cnt_after_8", DW'(beat_cnt), DW'(16'd8));

    $display("[TB] eop empty patterns");
    for (int k = 0; k < 4; k++) sendBeat(1'b1, 1'b1, 2'(k), 0);
    idle(2, 0);

    $display("[TB] ready drop at level 10 with continuous stream");
    for (int i = 0; i < 4; i++) sendBeat(1'b1, 1'b1, 2'd0, 9);
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b1, 1'b1, 2'd0, 10, 1'b0);
    idle(3, 10);
    applyStimulus(1'b0, 1'b0, 1'b0, 2'd0, 0, 1'b1);
    idle(3, 0);

    $display("[TB] overflow with beats in the window");
    idle(3, 8);
    applyStimulus(1'b1, 1'b1, 1'b1, 2'd0, 16, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b1, 2'd0, 16, 1'b0);
    idle(3, 16);
    applyStimulus(1'b0, 1'b0, 1'b0, 2'd0, 0, 1'b1);
    idle(4, 0);

    $display("[TB] framing sequence");
    sendBeat(1'b0, 1'b0, 2'd0, 0);
    sendBeat(1'b1, 1'b0, 2'd0, 0);
    sendBeat(1'b1, 1'b0, 2'd0, 0);
    sendBeat(1'b0, 1'b1, 2'd1, 0);
    sendBeat(1'b1, 1'b1, 2'd2, 0);
    idle(2, 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 2'd0, 0, 1'b1);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 400; i++) begin
      v = ($urandom_range(0, 9) < 7);
      s = 1'($urandom_range(0, 1));
      e = 1'($urandom_range(0, 1));
      r = $urandom_range(0, 19);
      if (r < 14)      lvl = $urandom_range(0, 9);
      else if (r < 18) lvl = $urandom_range(10, 15);
      else             lvl = DEPTH;
      applyStimulus(v, s, e, 2'($urandom_range(0, 3)), lvl, ($urandom_range(0, 15) == 0));
    end
    idle(4, 0);

    $display("[TB] reset mid-packet");
    applyStimulus(1'b0, 1'b0, 1'b0, 2'd0, 0, 1'b1);
    sendBeat(1'b1, 1'b0, 2'd0, 0);
    sendBeat(1'b0, 1'b0, 2'd0, 0);
    resetDut();
    sendBeat(1'b1, 1'b0, 2'd0, 0);
    sendBeat(1'b0, 1'b1, 2'd3, 0);
    idle(3, 0);

    checkOutput("pending_writes", DW'(exp_q.size()), '0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
